// File: rtl/accel_buf_pkg.sv
// Shared constants and helpers for the accelerator feature-map buffers.
package accel_buf_pkg;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 2;
    localparam int unsigned NUM_BANKS  = 2;

    // Address width for a given depth, never less than one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/sdp_ram_bank.sv
// Simple dual-port RAM for one channel of one bank: one write port, one registered read port.
module sdp_ram_bank
    import accel_buf_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 256,
    localparam int unsigned ADDR_W = clog2(DEPTH)
) (
    input  logic              clka,
    input  logic              rstb,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clka) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Only the output register is reset; array contents survive reset.
    always_ff @(posedge clka) begin
        if (!rstb) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pingpong_multich_ram.sv
// Double-buffered multi-channel feature-map buffer: producer fills one bank while the
// consumer drains the other, with done/valid bank handoff and sticky protocol errors.
module pingpong_multich_ram
    import accel_buf_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned RD_LAT = 2,
    localparam int unsigned ADDR_W = clog2(DEPTH)
) (
    input  logic                     clka,
    input  logic                     rstb,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [NUM_CH*DATA_W-1:0] wr_data,
    input  logic [NUM_CH-1:0]        wr_ch_mask,
    input  logic                     wr_done,
    output logic                     wr_ready,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        rd_addr,
    input  logic                     rd_done,
    output logic                     rd_bank_valid,
    output logic [NUM_CH*DATA_W-1:0] rd_data,
    output logic                     rd_valid,
    output logic                     wr_bank,
    output logic                     rd_bank,
    output logic                     err_wr,
    output logic                     err_rd
);

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $error("pingpong_multich_ram: RD_LAT must be 1 or 2");
    end

    logic [NUM_BANKS-1:0]     full_q, full_d;
    logic                     wr_bank_q, wr_bank_d;
    logic                     rd_bank_q, rd_bank_d;
    logic                     err_wr_q, err_wr_d;
    logic                     err_rd_q, err_rd_d;
    logic                     rd_sel_q;
    logic                     rd_v1_q;
    logic                     wr_go, rd_go;
    logic [DATA_W-1:0]        ram_rdata [NUM_BANKS][NUM_CH];
    logic [NUM_CH*DATA_W-1:0] mux_data;

    assign wr_ready      = ~full_q[wr_bank_q];
    assign rd_bank_valid = full_q[rd_bank_q];
    assign wr_go         = wr_en & wr_ready;
    assign rd_go         = rd_en & rd_bank_valid;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            sdp_ram_bank #(
                .DATA_W(DATA_W),
                .DEPTH (DEPTH)
            ) u_ram (
                .clka   (clka),
                .rstb   (rstb),
                .we_i   (wr_go && (wr_bank_q == 1'(b)) && wr_ch_mask[c]),
                .waddr_i(wr_addr),
                .wdata_i(wr_data[c*DATA_W +: DATA_W]),
                .re_i   (rd_go && (rd_bank_q == 1'(b))),
                .raddr_i(rd_addr),
                .rdata_o(ram_rdata[b][c])
            );
        end
    end

    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        err_wr_d  = err_wr_q | (~wr_ready & (wr_en | wr_done));
        err_rd_d  = err_rd_q | (~rd_bank_valid & (rd_en | rd_done));
        // wr_done and rd_done always address different banks, so both may apply.
        if (wr_done && wr_ready) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
        end
        if (rd_done && rd_bank_valid) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
    end

    // Bank select is captured at issue so a release right after a read cannot redirect it.
    always_comb begin
        mux_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            mux_data[c*DATA_W +: DATA_W] = ram_rdata[rd_sel_q][c];
        end
    end

    always_ff @(posedge clka) begin
        if (!rstb) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            err_wr_q  <= 1'b0;
            err_rd_q  <= 1'b0;
            rd_sel_q  <= 1'b0;
            rd_v1_q   <= 1'b0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            err_wr_q  <= err_wr_d;
            err_rd_q  <= err_rd_d;
            rd_v1_q   <= rd_go;
            if (rd_go) rd_sel_q <= rd_bank_q;
        end
    end

    if (RD_LAT == 1) begin : g_lat1
        assign rd_data  = mux_data;
        assign rd_valid = rd_v1_q;
    end else begin : g_lat2
        logic [NUM_CH*DATA_W-1:0] rd_data_q;
        logic                     rd_valid_q;

        always_ff @(posedge clka) begin
            if (!rstb) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_v1_q;
                if (rd_v1_q) rd_data_q <= mux_data;
            end
        end

        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end

    assign wr_bank = wr_bank_q;
    assign rd_bank = rd_bank_q;
    assign err_wr  = err_wr_q;
    assign err_rd  = err_rd_q;

endmodule

// File: tb/tb_pingpong_multich_ram.sv
// Bench for pingpong_multich_ram: RD_LAT=1 and RD_LAT=2 instances share stimulus and are
// scored against a bank/array model kept here.
module tb_pingpong_multich_ram;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned NCH   = 4;
    localparam int unsigned AW    = 8;
    localparam int unsigned BW    = NCH * DW;

    logic           clka = 1'b0;
    logic           rstb = 1'b0;
    logic           wr_en = 1'b0, wr_done = 1'b0, rd_en = 1'b0, rd_done = 1'b0;
    logic [AW-1:0]  wr_addr = '0, rd_addr = '0;
    logic [BW-1:0]  wr_data = '0;
    logic [NCH-1:0] wr_ch_mask = '0;

    logic          wr_ready1, rd_bank_valid1, rd_valid1, wr_bank1, rd_bank1, err_wr1, err_rd1;
    logic          wr_ready2, rd_bank_valid2, rd_valid2, wr_bank2, rd_bank2, err_wr2, err_rd2;
    logic [BW-1:0] rd_data1, rd_data2;
    logic [5:0]    st1, st2;

    always #5 clka = ~clka;

    pingpong_multich_ram #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_CH(NCH), .RD_LAT(1)) dut_l1 (
        .clka(clka), .rstb(rstb), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ch_mask(wr_ch_mask), .wr_done(wr_done), .wr_ready(wr_ready1), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_done(rd_done), .rd_bank_valid(rd_bank_valid1),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .wr_bank(wr_bank1), .rd_bank(rd_bank1),
        .err_wr(err_wr1), .err_rd(err_rd1)
    );

    pingpong_multich_ram #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_CH(NCH), .RD_LAT(2)) dut_l2 (
        .clka(clka), .rstb(rstb), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ch_mask(wr_ch_mask), .wr_done(wr_done), .wr_ready(wr_ready2), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_done(rd_done), .rd_bank_valid(rd_bank_valid2),
        .rd_data(rd_data2), .rd_valid(rd_valid2), .wr_bank(wr_bank2), .rd_bank(rd_bank2),
        .err_wr(err_wr2), .err_rd(err_rd2)
    );

    assign st1 = {wr_ready1, rd_bank_valid1, wr_bank1, rd_bank1, err_wr1, err_rd1};
    assign st2 = {wr_ready2, rd_bank_valid2, wr_bank2, rd_bank2, err_wr2, err_rd2};

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc = 0;

    typedef struct {
        int unsigned   cyc;
        logic [BW-1:0] data;
    } rd_ev_t;

    rd_ev_t exp1[$], exp2[$], act1[$], act2[$];

    // Reference model: two banks of NCH arrays plus ownership state.
    logic [DW-1:0] m_mem [2][NCH][DEPTH];
    logic [1:0]    m_full;
    logic          m_wb, m_rb, m_ew, m_er;

    function automatic logic [5:0] m_status();
        return {~m_full[m_wb], m_full[m_rb], m_wb, m_rb, m_ew, m_er};
    endfunction

    always @(posedge clka) cyc <= cyc + 1;

    always @(negedge clka) begin
        if (rd_valid1) act1.push_back('{cyc: cyc, data: rd_data1});
        if (rd_valid2) act2.push_back('{cyc: cyc, data: rd_data2});
    end

    // Drive one cycle of inputs, advance the model across the coming edge, wait to negedge.
    task automatic step(input logic we, input logic [AW-1:0] wa, input logic [BW-1:0] wd,
                        input logic [NCH-1:0] wm, input logic wdn, input logic re,
                        input logic [AW-1:0] ra, input logic rdn);
        logic          wok, rok;
        logic [BW-1:0] d;
        wr_en = we; wr_addr = wa; wr_data = wd; wr_ch_mask = wm; wr_done = wdn;
        rd_en = re; rd_addr = ra; rd_done = rdn;
        wok = ~m_full[m_wb];
        rok = m_full[m_rb];
        if (re) begin
            if (rok) begin
                for (int c = 0; c < NCH; c++) d[c*DW +: DW] = m_mem[m_rb][c][ra];
                exp1.push_back('{cyc: cyc + 1, data: d});
                exp2.push_back('{cyc: cyc + 2, data: d});
            end else begin
                m_er = 1'b1;
            end
        end
        if (we) begin
            if (wok) begin
                for (int c = 0; c < NCH; c++)
                    if (wm[c]) m_mem[m_wb][c][wa] = wd[c*DW +: DW];
            end else begin
                m_ew = 1'b1;
            end
        end
        if (wdn && !wok) m_ew = 1'b1;
        if (rdn && !rok) m_er = 1'b1;
        if (wdn && wok) m_full[m_wb] = 1'b1;
        if (rdn && rok) m_full[m_rb] = 1'b0;
        if (wdn && wok) m_wb = ~m_wb;
        if (rdn && rok) m_rb = ~m_rb;
        @(negedge clka);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, '0, 0, 0, '0, 0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [BW-1:0] d, input logic [NCH-1:0] m);
        step(1, a, d, m, 0, 0, '0, 0);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic done);
        step(0, '0, '0, '0, 0, 1, a, done);
    endtask

    task automatic do_reset();
        rstb = 1'b0;
        wr_en = 0; wr_done = 0; rd_en = 0; rd_done = 0;
        m_full = '0; m_wb = 0; m_rb = 0; m_ew = 0; m_er = 0;
        @(negedge clka);
        rstb = 1'b1;
        exp1.delete(); exp2.delete(); act1.delete(); act2.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (st1 !== 6'b100000 || st2 !== 6'b100000) begin
            n_bad++;
            $display("FAIL reset_status: lat1=%b lat2=%b want 100000", st1, st2);
        end
        n_cmp++;
        if (rd_valid1 !== 1'b0 || rd_valid2 !== 1'b0 || rd_data1 !== '0 || rd_data2 !== '0) begin
            n_bad++;
            $display("FAIL reset_read: v1=%b v2=%b d1=%h d2=%h want 0", rd_valid1, rd_valid2,
                     rd_data1, rd_data2);
        end
    endtask

    task automatic test_fill_read();
        logic [BW-1:0] d, want;
        do_reset();
        for (int a = 0; a < DEPTH; a++) begin
            for (int c = 0; c < NCH; c++) d[c*DW +: DW] = {8'(c), 8'(a)};
            wr(AW'(a), d, 4'hF);
        end
        step(0, '0, '0, '0, 1, 0, '0, 0);
        n_cmp++;
        if (wr_bank1 !== 1'b1 || wr_bank2 !== 1'b1 || rd_bank_valid1 !== 1'b1 ||
            rd_bank_valid2 !== 1'b1) begin
            n_bad++;
            $display("FAIL fill_handoff: wr_bank=%b/%b rd_bank_valid=%b/%b want 1", wr_bank1,
                     wr_bank2, rd_bank_valid1, rd_bank_valid2);
        end
        for (int c = 0; c < NCH; c++) want[c*DW +: DW] = {8'(c), 8'd5};
        rd(8'd5, 0);
        n_cmp++;
        if (rd_valid1 !== 1'b1 || rd_data1 !== want || rd_valid2 !== 1'b0) begin
            n_bad++;
            $display("FAIL fill_read_c1: v1=%b d1=%h v2=%b want v1=1 d1=%h v2=0", rd_valid1,
                     rd_data1, rd_valid2, want);
        end
        idle(1);
        n_cmp++;
        if (rd_valid2 !== 1'b1 || rd_data2 !== want || rd_valid1 !== 1'b0) begin
            n_bad++;
            $display("FAIL fill_read_c2: v2=%b d2=%h v1=%b want v2=1 d2=%h v1=0", rd_valid2,
                     rd_data2, rd_valid1, want);
        end
        idle(1);
        n_cmp++;
        if (rd_valid2 !== 1'b0 || rd_data2 !== want || rd_data1 !== want) begin
            n_bad++;
            $display("FAIL fill_read_hold: v2=%b d1=%h d2=%h want v2=0 data %h held", rd_valid2,
                     rd_data1, rd_data2, want);
        end
    endtask

    task automatic test_both_full();
        logic [BW-1:0] d, keep;
        do_reset();
        for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < 4; a++) begin
                d = {$urandom, $urandom};
                if (b == 0 && a == 1) keep = d;
                wr(AW'(a), d, 4'hF);
            end
            step(0, '0, '0, '0, 1, 0, '0, 0);
        end
        n_cmp++;
        if (wr_ready1 !== 1'b0 || wr_ready2 !== 1'b0) begin
            n_bad++;
            $display("FAIL both_full_ready: got %b/%b want 0", wr_ready1, wr_ready2);
        end
        wr(8'd1, ~keep, 4'hF);
        n_cmp++;
        if (err_wr1 !== 1'b1 || err_wr2 !== 1'b1 || err_rd1 !== 1'b0 || err_rd2 !== 1'b0) begin
            n_bad++;
            $display("FAIL both_full_err: err_wr=%b/%b err_rd=%b/%b want 1/1 0/0", err_wr1,
                     err_wr2, err_rd1, err_rd2);
        end
        rd(8'd1, 0);
        n_cmp++;
        if (rd_data1 !== keep) begin
            n_bad++;
            $display("FAIL both_full_keep_l1: got %h want %h", rd_data1, keep);
        end
        idle(1);
        n_cmp++;
        if (rd_data2 !== keep) begin
            n_bad++;
            $display("FAIL both_full_keep_l2: got %h want %h", rd_data2, keep);
        end
        step(0, '0, '0, '0, 0, 0, '0, 1);
        n_cmp++;
        if (wr_ready1 !== 1'b1 || wr_ready2 !== 1'b1 || wr_bank1 !== 1'b0 || wr_bank2 !== 1'b0 ||
            rd_bank1 !== 1'b1 || rd_bank2 !== 1'b1) begin
            n_bad++;
            $display("FAIL both_full_release: st=%b/%b want wr_ready=1 wr_bank=0 rd_bank=1",
                     st1, st2);
        end
    endtask

    task automatic test_mask();
        localparam logic [BW-1:0] Want = 64'h1111_AAAA_1111_AAAA;
        do_reset();
        wr(8'd7, {4{16'h1111}}, 4'hF);
        wr(8'd7, {4{16'hAAAA}}, 4'b0101);
        step(0, '0, '0, '0, 1, 0, '0, 0);
        rd(8'd7, 0);
        n_cmp++;
        if (rd_data1 !== Want) begin
            n_bad++;
            $display("FAIL mask_l1: got %h want %h", rd_data1, Want);
        end
        idle(1);
        n_cmp++;
        if (rd_data2 !== Want) begin
            n_bad++;
            $display("FAIL mask_l2: got %h want %h", rd_data2, Want);
        end
    endtask

    task automatic test_simul_done();
        do_reset();
        wr(8'd0, {$urandom, $urandom}, 4'hF);
        step(0, '0, '0, '0, 1, 0, '0, 0);
        step(0, '0, '0, '0, 1, 0, '0, 1);
        n_cmp++;
        if (st1 !== 6'b110100 || st2 !== 6'b110100) begin
            n_bad++;
            $display("FAIL simul_done: st=%b/%b want 110100", st1, st2);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int a = 0; a < 10; a++) wr(AW'(a), {$urandom, $urandom}, 4'hF);
        step(0, '0, '0, '0, 1, 0, '0, 0);
        for (int a = 0; a < 10; a++) rd(AW'(a), a == 9);
        idle(4);
        n_cmp++;
        if (act1.size() != 10 || act2.size() != 10 || exp1.size() != 10) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d/%0d model %0d want 10", act1.size(), act2.size(),
                     exp1.size());
        end
        for (int i = 0; i < exp1.size() && i < act1.size(); i++) begin
            n_cmp++;
            if (act1[i].cyc != exp1[i].cyc || act1[i].data !== exp1[i].data) begin
                n_bad++;
                $display("FAIL b2b_l1[%0d]: got cyc %0d %h want cyc %0d %h", i, act1[i].cyc,
                         act1[i].data, exp1[i].cyc, exp1[i].data);
            end
        end
        for (int i = 0; i < exp2.size() && i < act2.size(); i++) begin
            n_cmp++;
            if (act2[i].cyc != exp2[i].cyc || act2[i].data !== exp2[i].data) begin
                n_bad++;
                $display("FAIL b2b_l2[%0d]: got cyc %0d %h want cyc %0d %h", i, act2[i].cyc,
                         act2[i].data, exp2[i].cyc, exp2[i].data);
            end
        end
        n_cmp++;
        if (rd_bank_valid1 !== 1'b0 || rd_bank2 !== 1'b1 || err_rd2 !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_release: rbv=%b rd_bank=%b err_rd=%b want 0 1 0", rd_bank_valid1,
                     rd_bank2, err_rd2);
        end
    endtask

    task automatic test_reset_midburst();
        logic [BW-1:0] d;
        do_reset();
        for (int a = 0; a < 4; a++) begin
            d = {$urandom, $urandom};
            wr(AW'(a), d, 4'hF);
        end
        step(0, '0, '0, '0, 1, 0, '0, 0);
        rd(8'd3, 0);
        n_cmp++;
        if (rd_valid1 !== 1'b1 || rd_data1 !== d) begin
            n_bad++;
            $display("FAIL midburst_l1: v=%b d=%h want 1 %h", rd_valid1, rd_data1, d);
        end
        do_reset();
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (rd_valid2 !== 1'b0 || rd_valid1 !== 1'b0 || rd_data2 !== '0 || rd_data1 !== '0 ||
                st1 !== 6'b100000 || st2 !== 6'b100000) begin
                n_bad++;
                $display("FAIL midburst_reset[%0d]: v=%b/%b d=%h/%h st=%b/%b want all idle", i,
                         rd_valid1, rd_valid2, rd_data1, rd_data2, st1, st2);
            end
            idle(1);
        end
        rd(8'd0, 0);
        idle(2);
        n_cmp++;
        if (err_rd1 !== 1'b1 || err_rd2 !== 1'b1 || act1.size() != 0 || act2.size() != 0) begin
            n_bad++;
            $display("FAIL early_rd: err_rd=%b/%b valid_seen=%0d/%0d want 1/1 0/0", err_rd1,
                     err_rd2, act1.size(), act2.size());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < 16; a++) wr(AW'(a), {$urandom, $urandom}, 4'hF);
            step(0, '0, '0, '0, 1, 0, '0, 0);
        end
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), {$urandom, $urandom},
                 NCH'($urandom_range(0, 15)), $urandom_range(0, 9) == 0,
                 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                 $urandom_range(0, 7) == 0);
            n_cmp++;
            if (st1 !== m_status() || st2 !== m_status()) begin
                n_bad++;
                $display("FAIL rand_status[%0d]: got %b/%b want %b", i, st1, st2, m_status());
            end
        end
        idle(4);
        n_cmp++;
        if (act1.size() != exp1.size() || act2.size() != exp2.size()) begin
            n_bad++;
            $display("FAIL rand_count: got %0d/%0d want %0d/%0d", act1.size(), act2.size(),
                     exp1.size(), exp2.size());
        end
        for (int i = 0; i < exp1.size() && i < act1.size(); i++) begin
            n_cmp++;
            if (act1[i].cyc != exp1[i].cyc || act1[i].data !== exp1[i].data) begin
                n_bad++;
                $display("FAIL rand_l1[%0d]: got cyc %0d %h want cyc %0d %h", i, act1[i].cyc,
                         act1[i].data, exp1[i].cyc, exp1[i].data);
            end
        end
        for (int i = 0; i < exp2.size() && i < act2.size(); i++) begin
            n_cmp++;
            if (act2[i].cyc != exp2[i].cyc || act2[i].data !== exp2[i].data) begin
                n_bad++;
                $display("FAIL rand_l2[%0d]: got cyc %0d %h want cyc %0d %h", i, act2[i].cyc,
                         act2[i].data, exp2[i].cyc, exp2[i].data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_read();
        test_both_full();
        test_mask();
        test_simul_done();
        test_back_to_back();
        test_reset_midburst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pingpong_multich_ram.md
Name: pingpong_multich_ram

Overview:
Double-buffered, multi-channel feature-map buffer for the conv/pool controllers.
- A producer fills one bank while a consumer drains the other.
- Each bank holds NUM_CH parallel channel memories, so one address carries NUM_CH words per access.
- Bank ownership is exchanged by done/valid handshakes, with sticky protocol-error flags.
- Single clock domain. Read latency is selectable as 1 or 2 cycles.

Parameters:
- DATA_W, 16, width of one channel word
- DEPTH, 256, words per channel per bank; ADDR_W = clog2(DEPTH), minimum 1
- NUM_CH, 4, parallel channels per access
- RD_LAT, 2, read latency in cycles; only 1 or 2 are legal (elaboration error otherwise)

Ports:
- clka  in  1  clock
- rstb  in  1  reset, synchronous, active-low
- wr_en  in  1  write strobe into the current write bank
- wr_addr  in  ADDR_W  write address
- wr_data  in  NUM_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]
- wr_ch_mask  in  NUM_CH  per-channel write enable
- wr_done  in  1  pulse: producer finished the current write bank
- wr_ready  out  1  current write bank is free to fill
- rd_en  in  1  read strobe from the current read bank
- rd_addr  in  ADDR_W  read address
- rd_done  in  1  pulse: consumer released the current read bank
- rd_bank_valid  out  1  current read bank holds complete data
- rd_data  out  NUM_CH*DATA_W  read data
- rd_valid  out  1  rd_data valid this cycle
- wr_bank  out  1  index of the current write bank
- rd_bank  out  1  index of the current read bank
- err_wr  out  1  sticky producer protocol error
- err_rd  out  1  sticky consumer protocol error

Behaviour:
Reset (rstb==0 at posedge clka):
- full[1:0]=0, wr_bank=0, rd_bank=0.
- rd_valid=0, rd_data=0, err_wr=0, err_rd=0, read pipeline valid bits cleared.
- Memory contents are not cleared.
- Reset during operation discards in-flight reads; no rd_valid appears afterwards.

Combinational status:
- wr_ready = !full[wr_bank]
- rd_bank_valid = full[rd_bank]

Write path:
- wr_en && wr_ready: for each c with wr_ch_mask[c]=1, mem[wr_bank][c][wr_addr] <= channel c of wr_data. Unmasked channels are unchanged.
- wr_en && !wr_ready: write dropped, err_wr <= 1.

Bank handoff:
- wr_done && wr_ready: full[wr_bank] <= 1, wr_bank toggles. A write in the same cycle lands in the old bank.
- wr_done && !wr_ready: ignored, err_wr <= 1.
- rd_done && rd_bank_valid: full[rd_bank] <= 0, rd_bank toggles.
- rd_done && !rd_bank_valid: ignored, err_rd <= 1.
- wr_done and rd_done in the same cycle always target different banks; both take effect.
- With both banks full, wr_ready=0 until rd_done. With both empty, rd_bank_valid=0 until wr_done.

Read path:
- rd_en && rd_bank_valid: array is read at the issue edge.
  - RD_LAT=1: rd_data and rd_valid update at that edge.
  - RD_LAT=2: a second register stage adds one cycle.
  - Back-to-back reads give one result per cycle.
- rd_en && !rd_bank_valid: no access, no rd_valid, err_rd <= 1.
- rd_data holds its last value while rd_valid=0.
- rd_done with reads in flight: in-flight data is still delivered, because the array was sampled at issue.
- A producer write to the same address in the cycle after release does not corrupt delivered data.

Address:
- No wrap or bounds logic. Addresses >= DEPTH (non-power-of-2 DEPTH) are undefined usage.

Errors:
- err_wr and err_rd stay set until reset.

Decomposition:
Shared package (accel_buf_pkg):
- function clog2
- localparams RD_LAT_MIN=1, RD_LAT_MAX=2
- localparam NUM_BANKS=2

Sub-module sdp_ram_bank (DATA_W, DEPTH):
- Simple dual-port, one write port and one registered read port, both on clka.
- Instantiated 2*NUM_CH times in a generate loop.
- Read data muxed by the bank index captured at issue.

Top level holds the full flags, bank pointers, read pipeline and error flags.

Test Plan:
1. Default params. Write addr 0..255 with data {ch,addr}, mask 4'hF, then wr_done -> wr_bank=1, rd_bank_valid=1. Read addr 5 -> rd_valid exactly 2 cycles later, rd_data channel c = {c,5}.
2. Fill both banks with no rd_done -> wr_ready=0. A further wr_en sets err_wr=1 and bank contents are unchanged. rd_done -> wr_ready=1, and that bank's index equals wr_bank.
3. Write addr 7 with mask 4'b0101 and data 0xAAAA per channel, over a prior 0x1111 -> read gives ch0=ch2=0xAAAA, ch1=ch3=0x1111.
4. wr_done and rd_done in the same cycle with one bank full -> both toggles happen, full flags swap, no errors.
5. RD_LAT=1 build: continuous rd_en for 10 cycles -> rd_valid high 10 cycles starting 1 cycle after the first rd_en, data in address order. Issue rd_done on the last issue cycle -> all 10 results delivered correctly.
6. Reset mid-burst, one cycle after rd_en -> rd_valid stays 0, rd_data=0, full=0, wr_bank=rd_bank=0, errors cleared. rd_en before any wr_done -> err_rd=1, no rd_valid.
